// File: rtl/output_uart.sv
// output_uart: serializer for the nic8 output port.
// Every time the CPU loads its Q register, the byte on dbus is also captured
// into a small FIFO. The transmitter drains the FIFO as 8N1 frames on tx,
// sending the LSB first. The CPU is never stalled. A push into a full FIFO is
// dropped and sets a sticky overflow flag.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-low
//   loadQ     CPU load-Q strobe; a push happens on the same edge as the Q load
//   dbus      CPU data bus (8 bits)
//   tx        registered serial output, idles high
//   busy      transmitter not idle
//   level     bytes queued, not counting the byte in flight
//   full      level == DEPTH
//   overflow  sticky dropped-push flag
//
// Transmitter states
//   state   | meaning
//   S_IDLE  | line high, waiting for a queued byte
//   S_START | start bit (low) for CLKS_PER_BIT cycles
//   S_DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
//   S_STOP  | stop bit (high); pops the next byte directly if one is queued

module output_uart #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     loadQ,
  input  logic [7:0]               dbus,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      mem_q [DEPTH];

  logic            baud_done;
  logic            level_nz;
  logic            full_q;
  logic            pop;
  logic            push;

  assign baud_done = (baud_q == BAUD_LAST);
  assign level_nz  = (level_q != '0);
  assign full_q    = (level_q == LVL_FULL);

  // State register and all other flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage has no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dbus;
    end
  end

  // Next-state logic. Pop decisions look only at the registered level, so a
  // byte pushed on one edge is popped on the next edge at the earliest.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (level_nz) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) state_d = S_DATA;
      end
      S_DATA: begin
        if (baud_done && (bit_q == 3'd7)) state_d = S_STOP;
      end
      S_STOP: begin
        if (baud_done) begin
          if (level_nz) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    tx_d       = tx_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    baud_d     = (state_q == S_IDLE) ? '0 : baud_q + 1'b1;

    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
      tx_d    = 1'b0;
      baud_d  = '0;
      bit_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: tx_d = 1'b1;
        S_START: begin
          if (baud_done) begin
            tx_d   = shift_q[0];
            baud_d = '0;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_d = '0;
            if (bit_q == 3'd7) begin
              tx_d = 1'b1;
            end else begin
              // Next bit on the wire is bit 1 of the unshifted register.
              tx_d    = shift_q[1];
              shift_d = {1'b0, shift_q[7:1]};
              bit_d   = bit_q + 3'd1;
            end
          end
        end
        S_STOP: begin
          if (baud_done) begin
            tx_d   = 1'b1;
            baud_d = '0;
          end
        end
        default: tx_d = 1'b1;
      endcase
    end

    // A push into a full FIFO still fits when the transmitter pops on the same edge.
    push       = loadQ && (!full_q || pop);
    overflow_d = overflow_q | (loadQ & ~push);
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  assign tx       = tx_q;
  assign busy     = (state_q != S_IDLE);
  assign level    = level_q;
  assign full     = full_q;
  assign overflow = overflow_q;

endmodule
